nested_break_seq: RTL and testbench

- Cycle-by-cycle hardware sequencer for a two-level loop nest with early exit; its fixed-constant counterpart folds to a=110, b=20.
- Computes at runtime: for i<outer_limit { for j<inner_limit { if j==inner_break break; a+=1 } b+=B_STEP; if a>=a_stop break }.
- Used as a synthesis and equivalence test vehicle in which sequential RTL reproduces results the frontend otherwise constant-folds.

---
 rtl/nested_break_pkg.sv | 23 ++
 rtl/nested_break_seq_loop_counter.sv | 30 +++
 rtl/nested_break_seq.sv | 166 ++++++++++++++++
 tb/tb_nested_break_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/nested_break_pkg.sv
// Shared types and default widths for the nested-loop sequencer.
package nested_break_pkg;

    localparam int DEFAULT_W      = 32;
    localparam int DEFAULT_CW     = 8;
    localparam int DEFAULT_B_STEP = 2;

    typedef enum logic [1:0] {
        IDLE,
        INNER,
        OUTER_END,
        DONE
    } state_t;

    // Run configuration captured when a start is accepted
    typedef struct packed {
        logic [DEFAULT_CW-1:0] outer_limit;
        logic [DEFAULT_CW-1:0] inner_limit;
        logic [DEFAULT_CW-1:0] inner_break;
        logic [DEFAULT_W-1:0]  a_stop;
    } cfg_t;

endpackage

// File: rtl/nested_break_seq_loop_counter.sv
// Loop index counter: counts up while enabled and flags when it sits on
// either its limit or its match value.
module loop_counter #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          enable,
    input  logic [CW-1:0] limit,
    input  logic [CW-1:0] match,
    output logic          hit
);

    logic [CW-1:0] count;

    // Index register; clear has priority over enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign hit = (count == limit) || (count == match);

endmodule

// File: rtl/nested_break_seq.sv
// Two-level loop nest with early exit, executed one inner iteration per
// cycle: a counts inner iterations, b steps once per outer iteration.
module nested_break_seq
    import nested_break_pkg::*;
#(
    parameter int W      = DEFAULT_W,
    parameter int CW     = DEFAULT_CW,
    parameter int B_STEP = DEFAULT_B_STEP
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] outer_limit,
    input  logic [CW-1:0] inner_limit,
    input  logic [CW-1:0] inner_break,
    input  logic [W-1:0]  a_stop,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [W-1:0]  a,
    output logic [W-1:0]  b,
    output logic [CW-1:0] outer_count
);

    state_t        state;
    cfg_t          cfg;

    logic          i_clear;
    logic          i_enable;
    logic          i_hit;
    logic          j_clear;
    logic          j_enable;
    logic          j_hit;
    logic          finish_outer;
    logic [CW-1:0] i_last;

    // i sits on outer_limit-1 during the final outer iteration, so its hit
    // means "i+1 reaches outer_limit"; a zero limit never reaches INNER
    assign i_last       = cfg.outer_limit - CW'(1);
    assign finish_outer = i_hit || (a >= cfg.a_stop);

    loop_counter #(.CW(CW)) u_outer_idx (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (i_clear),
        .enable (i_enable),
        .limit  (i_last),
        .match  (i_last),
        .hit    (i_hit)
    );

    loop_counter #(.CW(CW)) u_inner_idx (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (j_clear),
        .enable (j_enable),
        .limit  (cfg.inner_limit),
        .match  (cfg.inner_break),
        .hit    (j_hit)
    );

    // Index counter control; abort freezes both indices for its cycle
    always_comb begin
        i_clear  = 1'b0;
        i_enable = 1'b0;
        j_clear  = 1'b0;
        j_enable = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    i_clear = 1'b1;
                    j_clear = 1'b1;
                end
            end
            INNER: begin
                if (!abort && !j_hit) begin
                    j_enable = 1'b1;
                end
            end
            OUTER_END: begin
                if (!abort) begin
                    i_enable = 1'b1;
                    if (!finish_outer) begin
                        j_clear = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Sequencer state, latched configuration, accumulators and status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cfg         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            a           <= '0;
            b           <= '0;
            outer_count <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg.outer_limit <= outer_limit;
                        cfg.inner_limit <= inner_limit;
                        cfg.inner_break <= inner_break;
                        cfg.a_stop      <= a_stop;
                        a               <= '0;
                        b               <= '0;
                        outer_count     <= '0;
                        if (outer_limit != '0) begin
                            state <= INNER;
                            busy  <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                INNER: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                    end else if (j_hit) begin
                        state <= OUTER_END;
                    end else begin
                        a <= a + W'(1);
                    end
                end
                OUTER_END: begin
                    if (abort) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        aborted <= 1'b1;
                    end else begin
                        b           <= b + W'(B_STEP);
                        outer_count <= outer_count + CW'(1);
                        if (finish_outer) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= INNER;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nested_break_seq.sv
// Directed bench for nested_break_seq with hand-computed results.
module tb_nested_break_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [7:0]  outer_limit;
    logic [7:0]  inner_limit;
    logic [7:0]  inner_break;
    logic [31:0] a_stop;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  outer_count;

    int total;
    int bad;

    nested_break_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .outer_limit (outer_limit),
        .inner_limit (inner_limit),
        .inner_break (inner_break),
        .a_stop      (a_stop),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .a           (a),
        .b           (b),
        .outer_count (outer_count)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Present a configuration and pulse start across one rising edge
    task automatic applyStimulus(input logic [7:0] ol, input logic [7:0] il,
                                 input logic [7:0] ib, input logic [31:0] as);
        outer_limit = ol;
        inner_limit = il;
        inner_break = ib;
        a_stop      = as;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count rising edges until done is seen; cycles=0 means done already high
    task automatic waitDone(input int budget, output int cycles);
        cycles = 0;
        while (!done && cycles < budget) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!done) checkOutput("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic checkResult(input string tag, input int cyc, input int exp_cyc,
                               input logic [31:0] exp_a, input logic [31:0] exp_b,
                               input logic [7:0] exp_oc);
        checkOutput({tag, "_cycle"}, cyc, exp_cyc);
        checkOutput({tag, "_a"}, a, exp_a);
        checkOutput({tag, "_b"}, b, exp_b);
        checkOutput({tag, "_outer_count"}, {24'd0, outer_count}, {24'd0, exp_oc});
        checkOutput({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_done_pulse_end"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int cyc;
        int seen_done;
        int seen_aborted;
        total       = 0;
        bad         = 0;
        start       = 1'b0;
        abort       = 1'b0;
        outer_limit = '0;
        inner_limit = '0;
        inner_break = '0;
        a_stop      = '0;
        rst_n       = 1'b1;

        #2 rst_n = 1'b0;
        #1;
        checkOutput("reset_a", a, 32'd0);
        checkOutput("reset_b", b, 32'd0);
        checkOutput("reset_outer_count", {24'd0, outer_count}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_done", {31'd0, done}, 32'd0);
        checkOutput("reset_aborted", {31'd0, aborted}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Nominal: k=11, 10 outer iterations of 13 cycles
        applyStimulus(8'd10, 8'd20, 8'd11, 32'hFFFF_FFFF);
        checkOutput("nominal_busy_after_start", {31'd0, busy}, 32'd1);
        waitDone(400, cyc);
        checkResult("nominal", cyc, 130, 32'd110, 32'd20, 8'd10);

        // Inner limit governs: k=4, 3 iterations of 6 cycles
        applyStimulus(8'd3, 8'd4, 8'd50, 32'hFFFF_FFFF);
        waitDone(400, cyc);
        checkResult("inner_limit", cyc, 18, 32'd12, 32'd6, 8'd3);

        // Threshold break: a reaches 33 >= 30 after the third iteration
        applyStimulus(8'd10, 8'd20, 8'd11, 32'd30);
        waitDone(400, cyc);
        checkResult("threshold", cyc, 39, 32'd33, 32'd6, 8'd3);

        // Zero trip count: done right after the start edge, busy never set
        applyStimulus(8'd0, 8'd20, 8'd11, 32'hFFFF_FFFF);
        checkOutput("zero_busy", {31'd0, busy}, 32'd0);
        waitDone(400, cyc);
        checkResult("zero", cyc, 0, 32'd0, 32'd0, 8'd0);

        // Abort sampled on edge 21: a=11+7, one outer iteration finished
        applyStimulus(8'd10, 8'd20, 8'd11, 32'hFFFF_FFFF);
        repeat (20) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("abort_pulse", {31'd0, aborted}, 32'd1);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_a", a, 32'd18);
        checkOutput("abort_b", b, 32'd2);
        checkOutput("abort_outer_count", {24'd0, outer_count}, 32'd1);
        seen_done    = 0;
        seen_aborted = 0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (done) seen_done++;
            if (aborted) seen_aborted++;
        end
        checkOutput("abort_no_done", seen_done, 32'd0);
        checkOutput("abort_single_pulse", seen_aborted, 32'd0);
        checkOutput("abort_a_held", a, 32'd18);

        applyStimulus(8'd10, 8'd20, 8'd11, 32'hFFFF_FFFF);
        waitDone(400, cyc);
        checkResult("after_abort", cyc, 130, 32'd110, 32'd20, 8'd10);

        // Reset mid-run clears everything without waiting for an edge
        applyStimulus(8'd10, 8'd20, 8'd11, 32'hFFFF_FFFF);
        repeat (50) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset_a", a, 32'd0);
        checkOutput("midreset_b", b, 32'd0);
        checkOutput("midreset_outer_count", {24'd0, outer_count}, 32'd0);
        checkOutput("midreset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (done || aborted || busy) seen_done++;
        end
        checkOutput("midreset_quiet", seen_done, 32'd0);

        // Second start and new config during a run are ignored
        applyStimulus(8'd10, 8'd20, 8'd11, 32'hFFFF_FFFF);
        repeat (5) @(posedge clk);
        #1;
        outer_limit = 8'd2;
        inner_limit = 8'd3;
        inner_break = 8'd1;
        a_stop      = 32'd5;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(400, cyc);
        checkResult("restart_ignored", cyc, 124, 32'd110, 32'd20, 8'd10);

        // Abort in IDLE does nothing
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        checkOutput("idle_abort_pulse", {31'd0, aborted}, 32'd0);
        checkOutput("idle_abort_a", a, 32'd110);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
